// File: rtl/tcp_tx_arb_pkg.sv
// tcp_tx_arb_pkg: shared FSM state type and SiTCP-XG transmit-port constants
package tcp_tx_arb_pkg;
    typedef enum logic {IDLE, BURST} state_t;
    localparam int SITCP_TX_W = 64;
    localparam int SITCP_TX_B_W = 4;
    localparam int SITCP_TX_MAX_B = 8;
    function automatic logic [SITCP_TX_B_W-1:0] clamp_b(input logic [SITCP_TX_B_W-1:0] b);
        return (b > SITCP_TX_B_W'(SITCP_TX_MAX_B)) ? SITCP_TX_B_W'(SITCP_TX_MAX_B) : b;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts just after last_owner
//   req        requesters, one bit per source
//   last_owner index of the previous owner
//   grant      one-hot winner, 0 when no request
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_owner,
    output logic [N-1:0]         grant
);
    // Walk from the farthest to the nearest candidate so the nearest requester overwrites.
    always_comb begin
        grant = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && i == (int'(last_owner) + k) % N) begin
                    grant = '0;
                    grant[i] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/tcp_tx_arbiter.sv
// tcp_tx_arbiter: round-robin share of the SiTCP-XG TCP transmit port between N_SRC producers
//   CLK/RST_N     user clock, synchronous active-low reset
//   ESTABLISHED   TCP session up; dropping it abandons the current record
//   SRC_*         per-source valid/last/data/byte-count and ready handshake
//   TX_AFULL      transmit almost-full, gates READY combinationally
//   TX_D/TX_B     registered word to SiTCP-XG, TX_B=0 means no data
//   GRANT         one-hot owner, TX_BYTE_CNT running total of bytes sent
module tcp_tx_arbiter
    import tcp_tx_arb_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int MAX_BURST = 256
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           ESTABLISHED,
    input  logic [N_SRC-1:0]               SRC_VALID,
    input  logic [N_SRC-1:0]               SRC_LAST,
    input  logic [SITCP_TX_W*N_SRC-1:0]    SRC_D,
    input  logic [SITCP_TX_B_W*N_SRC-1:0]  SRC_B,
    output logic [N_SRC-1:0]               SRC_READY,
    input  logic                           TX_AFULL,
    output logic [SITCP_TX_W-1:0]          TX_D,
    output logic [SITCP_TX_B_W-1:0]        TX_B,
    output logic [N_SRC-1:0]               GRANT,
    output logic [31:0]                    TX_BYTE_CNT
);
    localparam int LW = $clog2(N_SRC);

    state_t                  state;
    logic [LW-1:0]           last_owner;
    logic [LW-1:0]           owner;
    logic [15:0]             word_cnt;
    logic [N_SRC-1:0]        pick;
    logic [SITCP_TX_W-1:0]   sel_d;
    logic [SITCP_TX_B_W-1:0] sel_b;
    logic                    sel_last;
    logic                    accept;
    logic                    rel;

    rr_arbiter #(.N(N_SRC)) u_rr (
        .req        (SRC_VALID),
        .last_owner (last_owner),
        .grant      (pick)
    );

    assign SRC_READY = (state == BURST && ESTABLISHED && !TX_AFULL) ? GRANT : '0;
    assign accept    = |(SRC_READY & SRC_VALID);
    assign rel       = accept && (sel_last || word_cnt == 16'(MAX_BURST - 1));

    always_comb begin
        owner    = '0;
        sel_d    = '0;
        sel_b    = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (GRANT[i]) begin
                owner    = LW'(i);
                sel_d    = SRC_D[SITCP_TX_W*i +: SITCP_TX_W];
                sel_b    = SRC_B[SITCP_TX_B_W*i +: SITCP_TX_B_W];
                sel_last = SRC_LAST[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            GRANT       <= '0;
            last_owner  <= LW'(N_SRC - 1);
            word_cnt    <= '0;
            TX_D        <= '0;
            TX_B        <= '0;
            TX_BYTE_CNT <= '0;
        end else begin
            // Counts the word already on the output register, so it trails TX_B by a cycle.
            TX_BYTE_CNT <= TX_BYTE_CNT + 32'(TX_B);
            TX_B        <= accept ? clamp_b(sel_b) : '0;
            if (accept)
                TX_D <= sel_d;
            if (!ESTABLISHED) begin
                state    <= IDLE;
                GRANT    <= '0;
                word_cnt <= '0;
            end else if (state == IDLE) begin
                if (|SRC_VALID) begin
                    state    <= BURST;
                    GRANT    <= pick;
                    word_cnt <= '0;
                end
            end else if (rel) begin
                state      <= IDLE;
                GRANT      <= '0;
                last_owner <= owner;
                word_cnt   <= '0;
            end else if (accept) begin
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// tb_tcp_tx_arbiter: directed and randomized checks of tcp_tx_arbiter against a behavioural model
module tb_tcp_tx_arbiter;
    localparam int N  = 2;
    localparam int MB = 4;

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  b;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, est, afull;
    logic [N-1:0]    valid, last, ready, grant;
    logic [64*N-1:0] d;
    logic [4*N-1:0]  b;
    logic [63:0]     tx_d;
    logic [3:0]      tx_b;
    logic [31:0]     byte_cnt;

    tcp_tx_arbiter #(.N_SRC(N), .MAX_BURST(MB)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .ESTABLISHED (est),
        .SRC_VALID   (valid),
        .SRC_LAST    (last),
        .SRC_D       (d),
        .SRC_B       (b),
        .SRC_READY   (ready),
        .TX_AFULL    (afull),
        .TX_D        (tx_d),
        .TX_B        (tx_b),
        .GRANT       (grant),
        .TX_BYTE_CNT (byte_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    int          seq = 0;
    word_t       srcq [N][$];
    logic [63:0] emitted[$];
    logic [3:0]  emitted_b[$];
    logic        rst_nx = 1'b0, est_nx = 1'b1, afull_nx = 1'b0, gaps = 1'b0;
    logic [N-1:0] hs = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_w(input int s, input logic [3:0] bb, input logic lst);
        word_t w;
        w.d = {8'(s), 24'h0, 32'(seq)};
        w.b = bb;
        w.last = lst;
        srcq[s].push_back(w);
        seq++;
    endtask

    task automatic push_rec(input int s, input int n, input int bb);
        for (int i = 0; i < n; i++)
            push_w(s, bb < 0 ? 4'($urandom) : 4'(bb), i == n - 1);
    endtask

    // One clock of producer behaviour: retire last cycle's handshakes, present the queue heads.
    task automatic step();
        word_t w;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        rst_n = rst_nx;
        est   = est_nx;
        afull = afull_nx;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) w = srcq[i][0];
            else w = '{d: {$urandom, $urandom}, b: 4'($urandom), last: 1'b0};
            valid[i]     = srcq[i].size() > 0 && !(gaps && $urandom_range(3) == 0);
            d[64*i +: 64] = w.d;
            b[4*i +: 4]   = w.b;
            last[i]      = w.last;
        end
        #3;
        hs = ready & valid;
        if (tx_b != 0) begin
            emitted.push_back(tx_d);
            emitted_b.push_back(tx_b);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((srcq[0].size() + srcq[1].size()) > 0 && t < 500) begin
            step();
            t++;
        end
        check("drain_left", 64'(srcq[0].size() + srcq[1].size()), 64'd0);
        repeat (3) step();
    endtask

    // Behavioural model: owner index (-1 = none), words granted so far, previous owner.
    initial begin
        int          m_own, m_last, m_cnt, m_txb, bb, pick;
        logic [63:0] m_txd;
        logic [31:0] m_bytes;
        logic [N-1:0] rdy;
        logic        acc;
        m_own = -1; m_last = N - 1; m_cnt = 0; m_txb = 0; m_txd = '0; m_bytes = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            check("tx_d", tx_d, m_txd);
            check("tx_b", 64'(tx_b), 64'(m_txb));
            check("byte_cnt", 64'(byte_cnt), 64'(m_bytes));
            check("grant", 64'(grant), m_own < 0 ? 64'd0 : 64'd1 << m_own);
            rdy = (m_own >= 0 && est && !afull) ? N'(1 << m_own) : '0;
            check("ready", 64'(ready), 64'(rdy));
            if (!rst_n) begin
                m_own = -1; m_last = N - 1; m_cnt = 0; m_txb = 0; m_txd = '0; m_bytes = '0;
            end else begin
                acc = |(rdy & valid);
                m_bytes = m_bytes + 32'(m_txb);
                if (acc) begin
                    bb    = int'(b[4*m_own +: 4]);
                    m_txb = bb > 8 ? 8 : bb;
                    m_txd = d[64*m_own +: 64];
                end else begin
                    m_txb = 0;
                end
                if (!est) begin
                    m_own = -1;
                    m_cnt = 0;
                end else if (m_own < 0) begin
                    pick = -1;
                    for (int k = 1; k <= N; k++)
                        if (pick < 0 && valid[(m_last + k) % N]) pick = (m_last + k) % N;
                    m_own = pick;
                    m_cnt = 0;
                end else if (acc) begin
                    m_cnt++;
                    if (last[m_own] || m_cnt == MB) begin
                        m_last = m_own;
                        m_own  = -1;
                        m_cnt  = 0;
                    end
                end
            end
        end
    end

    initial begin
        int          fair_ord[12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        int          cap_ord[12]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        logic [3:0]  part_b[3]    = '{4'd8, 4'd3, 4'd8};
        int          s0;
        logic [31:0] bc0;
        rst_n = 1'b0; est = 1'b1; afull = 1'b0; valid = '0; last = '0; d = '0; b = '0;

        // Reset with sources already valid
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) push_rec(s, 3, 8);
        repeat (4) step();
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_tx_b", 64'(tx_b), 64'd0);
        check("rst_tx_d", tx_d, 64'd0);
        check("rst_bytes", 64'(byte_cnt), 64'd0);

        // First grant and fairness
        rst_nx = 1'b1;
        emitted.delete(); emitted_b.delete();
        step();
        step();
        check("first_grant", 64'(grant), 64'd1);
        check("first_ready", 64'(ready), 64'd1);
        step();
        check("first_tx_b", 64'(tx_b), 64'd8);
        check("first_src", 64'(tx_d[63:56]), 64'd0);
        for (int t = 0; t < 100 && emitted.size() < 6; t++) step();
        step();
        check("bytes_6w", 64'(byte_cnt), 64'd48);
        drain();
        check("fair_count", 64'(emitted.size()), 64'd12);
        for (int i = 0; i < 12 && i < emitted.size(); i++)
            check("fair_order", 64'(emitted[i][63:56]), 64'(fair_ord[i]));
        check("fair_bytes", 64'(byte_cnt), 64'd96);

        // Burst cap
        emitted.delete(); emitted_b.delete();
        push_rec(0, 10, 8);
        push_rec(1, 2, 8);
        drain();
        check("cap_count", 64'(emitted.size()), 64'd12);
        for (int i = 0; i < 12 && i < emitted.size(); i++)
            check("cap_order", 64'(emitted[i][63:56]), 64'(cap_ord[i]));

        // Backpressure
        emitted.delete(); emitted_b.delete();
        s0 = seq;
        push_rec(0, 8, 8);
        for (int t = 0; t < 100 && emitted.size() < 3; t++) step();
        afull_nx = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("afull_ready", 64'(ready), 64'd0);
            if (k > 0) check("afull_tx_b", 64'(tx_b), 64'd0);
        end
        afull_nx = 1'b0;
        step();
        check("afull_tail_tx_b", 64'(tx_b), 64'd0);
        drain();
        check("afull_count", 64'(emitted.size()), 64'd8);
        for (int i = 0; i < 8 && i < emitted.size(); i++)
            check("afull_data", emitted[i], {8'd0, 24'h0, 32'(s0 + i)});

        // Partial and oversized byte counts
        emitted.delete(); emitted_b.delete();
        bc0 = byte_cnt;
        push_w(0, 4'd8, 1'b0);
        push_w(0, 4'd3, 1'b0);
        push_w(0, 4'd0, 1'b0);
        push_w(0, 4'd12, 1'b1);
        drain();
        check("part_bytes", 64'(byte_cnt - bc0), 64'd19);
        check("part_count", 64'(emitted_b.size()), 64'd3);
        for (int i = 0; i < 3 && i < emitted_b.size(); i++)
            check("part_tx_b", 64'(emitted_b[i]), 64'(part_b[i]));

        // Disconnect mid-record and resume from last_owner+1
        emitted.delete(); emitted_b.delete();
        push_rec(1, 6, 8);
        push_rec(0, 2, 8);
        for (int t = 0; t < 100 && emitted.size() < 2; t++) step();
        check("disc_pre_grant", 64'(grant), 64'd2);
        est_nx = 1'b0;
        step();
        check("disc_ready", 64'(ready), 64'd0);
        step();
        check("disc_grant", 64'(grant), 64'd0);
        step();
        est_nx = 1'b1;
        step();
        step();
        check("reconn_grant", 64'(grant), 64'd2);
        drain();

        // Randomized traffic with gaps, backpressure, disconnects and rare resets
        gaps = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            for (int s = 0; s < N; s++)
                if (srcq[s].size() < 4 && $urandom_range(3) == 0)
                    push_rec(s, int'($urandom_range(10, 1)), -1);
            afull_nx = $urandom_range(7) == 0;
            if (est_nx) est_nx = $urandom_range(199) != 0;
            else est_nx = $urandom_range(3) == 0;
            rst_nx = $urandom_range(999) != 0;
            step();
        end
        gaps = 1'b0; afull_nx = 1'b0; est_nx = 1'b1; rst_nx = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
